// File: rtl/branch_predictor_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Zero-latency lookup from registered state; trained by execute, reports mispredicts.
module branch_predictor_btb #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_uncond,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_tgt,
  input  logic              flush,
  output logic              mispredict,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic [CNT_W-1:0]  upd_cnt,
  output logic              err
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [CTR_W-1:0] CTR_WT  = ~CTR_WNT;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || CTR_W < 1 || CNT_W < 1 || TAG_W < 1) begin : g_param_chk
    $error("branch_predictor_btb: illegal parameter combination");
  end

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, accept;
  logic [CTR_W-1:0] up_ctr;

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
  assign up_idx = upd_pc[IDX_W:1];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+1];

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_hit ? tgt_q[lk_idx] : '0;

  assign err        = upd_valid & upd_pc[0];
  assign accept     = upd_valid & ~err;
  assign mispredict = accept & ((upd_pred_taken != upd_taken) |
                                (upd_taken & (upd_pred_tgt != upd_target)));

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    up_ctr = ctr_q[up_idx];
    if (upd_uncond)
      up_ctr = CTR_MAX;
    else if (upd_taken) begin
      if (ctr_q[up_idx] != CTR_MAX) up_ctr = ctr_q[up_idx] + 1'b1;
    end else begin
      if (ctr_q[up_idx] != '0) up_ctr = ctr_q[up_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      mispred_cnt <= '0;
      upd_cnt     <= '0;
    end else begin
      if (accept) begin
        if (up_hit) begin
          ctr_q[up_idx] <= up_ctr;
          if (upd_taken) tgt_q[up_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[up_idx] <= 1'b1;
          tag_q[up_idx]   <= up_tag;
          tgt_q[up_idx]   <= upd_target;
          ctr_q[up_idx]   <= upd_uncond ? CTR_MAX : CTR_WT;
        end
        if (upd_cnt != '1) upd_cnt <= upd_cnt + 1'b1;
        if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
      end
      // flush overrides any same-cycle allocation; ctr/tag/target survive
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed cases plus random traffic
// compared against an arithmetic reference model of the table.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid, upd_uncond, upd_taken, upd_pred_taken, flush;
  logic [15:0] upd_pc, upd_target, upd_pred_tgt;
  logic        mispredict, err;
  logic [15:0] mispred_cnt, upd_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain integers per slot
  bit m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_mis, m_upd;

  branch_predictor_btb dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_tgt(upd_pred_tgt),
    .flush(flush), .mispredict(mispredict), .mispred_cnt(mispred_cnt),
    .upd_cnt(upd_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int slot(input int pc);
    return (pc / 2) % 16;
  endfunction

  function automatic int tagof(input int pc);
    return pc / 32;
  endfunction

  function automatic bit m_hit(input int pc);
    return m_valid[slot(pc)] && m_tag[slot(pc)] == tagof(pc);
  endfunction

  function automatic bit m_err();
    return upd_valid && (int'(upd_pc) % 2 == 1);
  endfunction

  function automatic bit m_mispred();
    return upd_valid && !m_err() &&
           (upd_pred_taken != upd_taken || (upd_taken && upd_pred_tgt != upd_target));
  endfunction

  task automatic model_clock();
    int s;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_mis = 0; m_upd = 0;
      return;
    end
    if (upd_valid && !m_err()) begin
      s = slot(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_uncond)     m_ctr[s] = 3;
        else if (upd_taken) m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        else                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        if (upd_taken) m_tgt[s] = upd_target;
      end else if (upd_taken) begin
        m_valid[s] = 1; m_tag[s] = tagof(upd_pc); m_tgt[s] = upd_target;
        m_ctr[s] = upd_uncond ? 3 : 2;
      end
      if (m_mispred()) m_mis = (m_mis + 1 > 65535) ? 65535 : m_mis + 1;
      m_upd = (m_upd + 1 > 65535) ? 65535 : m_upd + 1;
    end
    if (flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
  endtask

  // called just after a negedge with inputs already driven
  task automatic cycle();
    bit h;
    #1;
    h = m_hit(lookup_pc);
    chk("pred_hit", pred_hit, h);
    chk("pred_taken", pred_taken, h && m_ctr[slot(lookup_pc)] >= 2);
    chk("pred_target", pred_target, h ? m_tgt[slot(lookup_pc)] : 0);
    chk("mispredict", mispredict, m_mispred());
    chk("err", err, m_err());
    chk("mispred_cnt", mispred_cnt, m_mis);
    chk("upd_cnt", upd_cnt, m_upd);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] lpc);
    upd_valid = 0; upd_uncond = 0; upd_taken = 0; flush = 0;
    lookup_pc = lpc;
  endtask

  task automatic upd(input logic [15:0] pc, input logic unc, input logic tk,
                     input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt);
    upd_valid = 1; upd_pc = pc; upd_uncond = unc; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_tgt = ptgt; flush = 0;
  endtask

  initial begin
    int lp;
    rst = 1; lookup_pc = 16'h0010; upd_valid = 0; upd_pc = 0; upd_uncond = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_tgt = 0; flush = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_mis = 0; m_upd = 0;
    @(negedge clk);
    upd(16'h0010, 0, 1, 16'h0040, 0, 0);  // ignored during reset
    cycle();
    rst = 0;

    idle(16'h0010);
    #1;
    chk("rst_hit", pred_hit, 0);
    chk("rst_taken", pred_taken, 0);
    chk("rst_target", pred_target, 16'h0000);
    chk("rst_mcnt", mispred_cnt, 0);
    chk("rst_ucnt", upd_cnt, 0);
    cycle();

    upd(16'h0010, 0, 1, 16'h0040, 0, 16'h0000);
    #1 chk("alloc_mispred", mispredict, 1);
    cycle();
    idle(16'h0010);
    #1;
    chk("alloc_hit", pred_hit, 1);
    chk("alloc_taken", pred_taken, 1);
    chk("alloc_target", pred_target, 16'h0040);
    chk("alloc_ucnt", upd_cnt, 1);
    cycle();
    upd(16'h0010, 0, 0, 16'h0000, 1, 16'h0040); cycle();
    idle(16'h0010);
    #1 chk("weak_nt_hit", pred_hit, 1);
    chk("weak_nt_taken", pred_taken, 0);
    cycle();

    repeat (4) begin upd(16'h0010, 0, 1, 16'h0040, 1, 16'h0040); cycle(); end
    upd(16'h0010, 0, 0, 16'h0000, 1, 16'h0040); cycle();
    idle(16'h0010);
    #1 chk("sat_then_dec_taken", pred_taken, 1);
    cycle();
    upd(16'h0010, 0, 0, 16'h0000, 1, 16'h0040); cycle();
    idle(16'h0010);
    #1 chk("sat_dec_twice", pred_taken, 0);
    cycle();
    upd(16'h0010, 0, 1, 16'h0040, 0, 16'h0040); cycle();

    upd(16'h0020, 1, 1, 16'h0200, 0, 16'h0000); cycle();
    upd(16'h0020, 0, 0, 16'h0000, 1, 16'h0200); cycle();
    idle(16'h0020);
    #1 chk("jump_ctr_max", pred_taken, 1);
    cycle();

    idle(16'h0030);
    #1 chk("alias_miss", pred_hit, 0);
    cycle();
    upd(16'h0030, 0, 0, 16'h0000, 0, 16'h0000); cycle();
    idle(16'h0030); cycle();
    idle(16'h0010);
    #1 chk("alias_keep", pred_hit, 1);
    cycle();
    upd(16'h0030, 0, 1, 16'h0080, 0, 16'h0000); cycle();
    idle(16'h0030);
    #1 chk("alias_repl_tgt", pred_target, 16'h0080);
    cycle();
    idle(16'h0010);
    #1 chk("alias_evicted", pred_hit, 0);
    cycle();

    upd(16'h0030, 0, 1, 16'h0090, 1, 16'h0080);
    lookup_pc = 16'h0030;
    #1 chk("same_cycle_old", pred_target, 16'h0080);
    cycle();
    idle(16'h0030);
    #1 chk("same_cycle_new", pred_target, 16'h0090);
    cycle();
    upd(16'h0030, 0, 0, 16'h0000, 1, 16'h0090);
    #1 chk("mispred_dir", mispredict, 1);
    cycle();

    upd(16'h0031, 0, 1, 16'h0444, 0, 16'h0000);
    #1 chk("err_set", err, 1);
    chk("err_no_mispred", mispredict, 0);
    cycle();
    idle(16'h0030);
    #1 chk("err_no_write", pred_target, 16'h0090);
    cycle();

    upd(16'h0050, 0, 1, 16'h0100, 0, 16'h0000);
    flush = 1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      idle(16'(i * 32 + 16)); #1 chk("flush_miss", pred_hit, 0); cycle();
    end

    // random traffic over a few aliasing tags so hits and evictions are frequent
    repeat (3000) begin
      lp = ($urandom_range(0, 3) * 32) + ($urandom_range(0, 15) * 2);
      lookup_pc = 16'(lp);
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = 16'(($urandom_range(0, 3) * 32) + ($urandom_range(0, 15) * 2) +
                   ($urandom_range(0, 15) == 0 ? 1 : 0));
      upd_uncond = ($urandom_range(0, 3) == 0);
      upd_taken = upd_uncond ? 1'b1 : 1'($urandom_range(0, 1));
      upd_target = 16'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 1) begin
        upd_pred_taken = m_hit(upd_pc) && m_ctr[slot(upd_pc)] >= 2;
        upd_pred_tgt = m_hit(upd_pc) ? 16'(m_tgt[slot(upd_pc)]) : 16'h0;
      end else begin
        upd_pred_taken = 1'($urandom_range(0, 1));
        upd_pred_tgt = 16'($urandom_range(0, 7) * 4);
      end
      flush = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 255) == 0);
      cycle();
    end
    rst = 0;

    // saturate the mispredict counter with not-taken misses
    repeat (65535) begin
      upd(16'h0100, 0, 0, 16'h0000, 1, 16'h0000);
      lookup_pc = 16'h0100;
      cycle();
    end
    upd(16'h0100, 0, 0, 16'h0000, 1, 16'h0000); cycle();
    idle(16'h0100);
    #1 chk("mcnt_sat", mispred_cnt, 16'hFFFF);
    chk("ucnt_sat", upd_cnt, 16'hFFFF);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
